// File: rtl/hsv_param_ctrl_pkg.sv
// Shared types and default ranges for the HSV set-point controller.
package hsv_pkg;

  typedef enum logic [2:0] {
    MODE_FIXED  = 3'd0,
    MODE_STEP60 = 3'd1,
    MODE_SWEEP  = 3'd2,
    MODE_ADJ_H  = 3'd3,
    MODE_ADJ_S  = 3'd4,
    MODE_ADJ_V  = 3'd5,
    MODE_HOLD   = 3'd6,
    MODE_PRESET = 3'd7
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRESS  = 2'd1,
    ST_REPEAT = 2'd2
  } adj_state_e;

  localparam int HUE_MAX_DEF = 359;
  localparam int SV_MAX_DEF  = 100;

endpackage

// File: rtl/hsv_param_ctrl_if.sv
// Control/set-point bundle between mode-select logic, the controller and the HSV-to-RGB path.
interface hsv_param_ctrl_if #(parameter int W = 9);

  hsv_pkg::mode_e mode;
  logic           btn;
  logic           dir;
  logic [W-1:0]   hue;
  logic [W-1:0]   sat;
  logic [W-1:0]   val;
  logic           step_pulse;

  modport master (output mode, output btn, output dir,
                  input hue, input sat, input val, input step_pulse);

  modport slave  (input mode, input btn, input dir,
                  output hue, output sat, output val, output step_pulse);

endinterface

// File: rtl/hsv_param_ctrl_wrap_step.sv
// One +1/-1 step of a bounded value; wraps at the ends, or saturates when clamp is set.
module hsv_wrap_step #(
  parameter int W = 9
) (
  input  logic [W-1:0] value,
  input  logic         dir,
  input  logic [W-1:0] max_val,
  input  logic         clamp,
  output logic [W-1:0] next_val
);

  localparam logic [W-1:0] ONE = W'(1);

  // Anything above max is treated as already past the top, so up goes to 0 and down to max.
  always_comb begin
    next_val = value;
    if (!dir) begin
      if (value >= max_val) next_val = clamp ? max_val : '0;
      else                  next_val = value + ONE;
    end else begin
      if (value == '0)          next_val = clamp ? '0 : max_val;
      else if (value > max_val) next_val = max_val;
      else                      next_val = value - ONE;
    end
  end

endmodule

// File: rtl/hsv_param_ctrl.sv
// Button/mode driven hue/sat/val set-point generator with press/hold auto-repeat.
// Define HSV_SV_CLAMP_EN to make sat/val saturate instead of wrap.
module hsv_param_ctrl
  import hsv_pkg::*;
#(
  parameter int W          = 9,
  parameter int HUE_MAX    = HUE_MAX_DEF,
  parameter int SV_MAX     = SV_MAX_DEF,
  parameter int HUE_DEF    = 120,
  parameter int SV_DEF     = 50,
  parameter int CNT_W      = 22,
  parameter int STEP60_CYC = 2**22,
  parameter int SWEEP_CYC  = 2**19,
  parameter int HOLD_CYC   = 2**21,
  parameter int REPEAT_CYC = 2**20
) (
  input  logic              clk,
  input  logic              reset,
  hsv_param_ctrl_if.slave   bus
);

`ifdef HSV_SV_CLAMP_EN
  localparam logic SV_CLAMP = 1'b1;
`else
  localparam logic SV_CLAMP = 1'b0;
`endif

  localparam logic [W-1:0]     HUE_MAX_V   = W'(HUE_MAX);
  localparam logic [W-1:0]     SV_MAX_V    = W'(SV_MAX);
  localparam logic [W-1:0]     HUE_DEF_V   = W'(HUE_DEF);
  localparam logic [W-1:0]     SV_DEF_V    = W'(SV_DEF);
  localparam logic [W:0]       HUE_MAX_X   = (W+1)'(HUE_MAX);
  localparam logic [W:0]       HUE_MOD_X   = (W+1)'(HUE_MAX + 1);
  localparam logic [W:0]       SIXTY_X     = (W+1)'(60);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] STEP60_LAST = CNT_W'(STEP60_CYC - 1);
  localparam logic [CNT_W-1:0] SWEEP_LAST  = CNT_W'(SWEEP_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYC - 1);

  mode_e            mode_q;
  adj_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [W-1:0]     hue_q, sat_q, val_q;
  logic [W-1:0]     hue_nxt, sat_nxt, val_nxt;
  logic             pulse_q, pulse_nxt;
  logic [W-1:0]     hue_adj, sat_adj, val_adj, hue_inc;
  logic [W:0]       hue_sum, hue_sub;
  logic [W-1:0]     hue_step60;
  logic             mode_change, adj_step;

  hsv_wrap_step #(.W(W)) u_hue_adj (.value(hue_q), .dir(bus.dir), .max_val(HUE_MAX_V), .clamp(1'b0),     .next_val(hue_adj));
  hsv_wrap_step #(.W(W)) u_sat_adj (.value(sat_q), .dir(bus.dir), .max_val(SV_MAX_V),  .clamp(SV_CLAMP), .next_val(sat_adj));
  hsv_wrap_step #(.W(W)) u_val_adj (.value(val_q), .dir(bus.dir), .max_val(SV_MAX_V),  .clamp(SV_CLAMP), .next_val(val_adj));
  hsv_wrap_step #(.W(W)) u_hue_inc (.value(hue_q), .dir(1'b0),    .max_val(HUE_MAX_V), .clamp(1'b0),     .next_val(hue_inc));

  always_comb begin
    hue_sum    = {1'b0, hue_q} + SIXTY_X;
    hue_sub    = hue_sum - HUE_MOD_X;
    hue_step60 = (hue_sum > HUE_MAX_X) ? hue_sub[W-1:0] : hue_sum[W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q  <= MODE_FIXED;
      state   <= ST_IDLE;
      cnt     <= '0;
      hue_q   <= '0;
      sat_q   <= '0;
      val_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      mode_q  <= bus.mode;
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      hue_q   <= hue_nxt;
      sat_q   <= sat_nxt;
      val_q   <= val_nxt;
      pulse_q <= pulse_nxt;
    end
  end

  // Stepping modes do nothing on a mode-change cycle; FIXED/PRESET loads still apply.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    hue_nxt     = hue_q;
    sat_nxt     = sat_q;
    val_nxt     = val_q;
    pulse_nxt   = 1'b0;
    adj_step    = 1'b0;
    mode_change = (bus.mode != mode_q);

    case (bus.mode)
      MODE_FIXED: begin
        hue_nxt   = HUE_DEF_V;
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
      MODE_STEP60: begin
        state_nxt = ST_IDLE;
        if (!mode_change) begin
          if (cnt == STEP60_LAST) begin
            cnt_nxt   = '0;
            hue_nxt   = hue_step60;
            pulse_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
      end
      MODE_SWEEP: begin
        state_nxt = ST_IDLE;
        if (!mode_change) begin
          if (cnt == SWEEP_LAST) begin
            cnt_nxt   = '0;
            hue_nxt   = hue_inc;
            pulse_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
      end
      MODE_ADJ_H, MODE_ADJ_S, MODE_ADJ_V: begin
        if (!mode_change) begin
          case (state)
            ST_IDLE: begin
              cnt_nxt = '0;
              if (bus.btn) begin
                adj_step  = 1'b1;
                state_nxt = ST_PRESS;
              end
            end
            ST_PRESS, ST_REPEAT: begin
              if (!bus.btn) begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
              end else if (cnt == ((state == ST_PRESS) ? HOLD_LAST : REPEAT_LAST)) begin
                adj_step  = 1'b1;
                state_nxt = ST_REPEAT;
                cnt_nxt   = '0;
              end else begin
                cnt_nxt = cnt + CNT_ONE;
              end
            end
            default: begin
              state_nxt = ST_IDLE;
              cnt_nxt   = '0;
            end
          endcase
          if (adj_step) begin
            pulse_nxt = 1'b1;
            if (bus.mode == MODE_ADJ_H)      hue_nxt = hue_adj;
            else if (bus.mode == MODE_ADJ_S) sat_nxt = sat_adj;
            else                             val_nxt = val_adj;
          end
        end
      end
      MODE_PRESET: begin
        hue_nxt   = HUE_DEF_V;
        sat_nxt   = SV_DEF_V;
        val_nxt   = SV_DEF_V;
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase

    if (mode_change) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
    end
  end

  assign bus.hue        = hue_q;
  assign bus.sat        = sat_q;
  assign bus.val        = val_q;
  assign bus.step_pulse = pulse_q;

endmodule

// File: tb/tb_hsv_param_ctrl.sv
// Directed bench for hsv_param_ctrl with shortened rates; honours HSV_SV_CLAMP_EN in its expectations.
module tb_hsv_param_ctrl;
  import hsv_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  hsv_param_ctrl_if #(.W(9)) bus ();

  hsv_param_ctrl #(
    .W(9), .HUE_MAX(359), .SV_MAX(100), .HUE_DEF(120), .SV_DEF(50), .CNT_W(22),
    .STEP60_CYC(4), .SWEEP_CYC(2), .HOLD_CYC(5), .REPEAT_CYC(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef HSV_SV_CLAMP_EN
  localparam int SAT_HOLD = 100;
  localparam int SAT_R1   = 100;
  localparam int SAT_R2   = 100;
`else
  localparam int SAT_HOLD = 0;
  localparam int SAT_R1   = 1;
  localparam int SAT_R2   = 2;
`endif

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input mode_e m, input logic b, input logic d, input int n);
    bus.mode = m;
    bus.btn  = b;
    bus.dir  = d;
    tick(n);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] pick(input mode_e m);
    if (m == MODE_ADJ_S)      return {23'd0, bus.sat};
    else if (m == MODE_ADJ_V) return {23'd0, bus.val};
    else                      return {23'd0, bus.hue};
  endfunction

  // Hold the button in an adjust mode until the target value shows up, then let go.
  task automatic rampTo(input mode_e m, input logic d, input int target, input string tag);
    applyStimulus(m, 1'b0, d, 1);
    bus.btn = 1'b1;
    for (int i = 0; i < 400 && pick(m) != 32'(target); i++) tick(1);
    bus.btn = 1'b0;
    tick(1);
    checkOutput(tag, pick(m), 32'(target));
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    bus.mode = MODE_PRESET;
    bus.btn  = 1'b0;
    bus.dir  = 1'b0;
    tick(2);
    checkOutput("rst_hue", {23'd0, bus.hue}, 0);
    checkOutput("rst_sat", {23'd0, bus.sat}, 0);
    checkOutput("rst_val", {23'd0, bus.val}, 0);
    checkOutput("rst_pulse", {31'd0, bus.step_pulse}, 0);

    reset = 1'b0;
    applyStimulus(MODE_PRESET, 1'b1, 1'b0, 1);
    checkOutput("preset_hue", {23'd0, bus.hue}, 120);
    checkOutput("preset_sat", {23'd0, bus.sat}, 50);
    checkOutput("preset_val", {23'd0, bus.val}, 50);
    checkOutput("preset_pulse", {31'd0, bus.step_pulse}, 0);

    rampTo(MODE_ADJ_S, 1'b0, 99, "ramp_sat99");
    bus.btn = 1'b1;
    tick(1);
    checkOutput("sat_first", {23'd0, bus.sat}, 100);
    checkOutput("sat_first_pulse", {31'd0, bus.step_pulse}, 1);
    tick(4);
    checkOutput("sat_press_wait", {23'd0, bus.sat}, 100);
    checkOutput("sat_press_nopulse", {31'd0, bus.step_pulse}, 0);
    tick(1);
    checkOutput("sat_hold", {23'd0, bus.sat}, 32'(SAT_HOLD));
    checkOutput("sat_hold_pulse", {31'd0, bus.step_pulse}, 1);
    tick(3);
    checkOutput("sat_rep1", {23'd0, bus.sat}, 32'(SAT_R1));
    tick(3);
    checkOutput("sat_rep2", {23'd0, bus.sat}, 32'(SAT_R2));
    tick(2);
    bus.btn = 1'b0;
    tick(1);
    checkOutput("sat_release", {23'd0, bus.sat}, 32'(SAT_R2));
    checkOutput("sat_release_pulse", {31'd0, bus.step_pulse}, 0);

    bus.btn = 1'b1;
    tick(8);
    reset = 1'b1;
    tick(1);
    checkOutput("midrep_rst_hue", {23'd0, bus.hue}, 0);
    checkOutput("midrep_rst_sat", {23'd0, bus.sat}, 0);
    checkOutput("midrep_rst_val", {23'd0, bus.val}, 0);
    reset = 1'b0;

    applyStimulus(MODE_ADJ_H, 1'b0, 1'b1, 1);
    applyStimulus(MODE_ADJ_H, 1'b1, 1'b1, 1);
    checkOutput("adjh_down_wrap", {23'd0, bus.hue}, 359);
    checkOutput("adjh_pulse", {31'd0, bus.step_pulse}, 1);
    applyStimulus(MODE_ADJ_H, 1'b0, 1'b1, 1);
    checkOutput("adjh_single_pulse", {31'd0, bus.step_pulse}, 0);
    tick(6);
    checkOutput("adjh_idle_hold", {23'd0, bus.hue}, 359);
    applyStimulus(MODE_ADJ_H, 1'b1, 1'b1, 1);
    checkOutput("adjh_idle_restep", {23'd0, bus.hue}, 358);

    rampTo(MODE_ADJ_H, 1'b1, 300, "ramp_hue300");
    applyStimulus(MODE_STEP60, 1'b0, 1'b0, 1);
    tick(3);
    checkOutput("s60_wait", {23'd0, bus.hue}, 300);
    tick(1);
    checkOutput("s60_wrap", {23'd0, bus.hue}, 0);
    checkOutput("s60_pulse", {31'd0, bus.step_pulse}, 1);
    tick(3);
    checkOutput("s60_gap_pulse", {31'd0, bus.step_pulse}, 0);
    tick(1);
    checkOutput("s60_second", {23'd0, bus.hue}, 60);

    rampTo(MODE_ADJ_H, 1'b1, 358, "ramp_hue358");
    applyStimulus(MODE_SWEEP, 1'b0, 1'b0, 1);
    tick(1);
    checkOutput("sweep_wait", {23'd0, bus.hue}, 358);
    tick(1);
    checkOutput("sweep_359", {23'd0, bus.hue}, 359);
    checkOutput("sweep_pulse", {31'd0, bus.step_pulse}, 1);
    tick(2);
    checkOutput("sweep_wrap0", {23'd0, bus.hue}, 0);

    applyStimulus(MODE_FIXED, 1'b1, 1'b0, 1);
    checkOutput("fixed_hue", {23'd0, bus.hue}, 120);
    checkOutput("fixed_pulse", {31'd0, bus.step_pulse}, 0);

    applyStimulus(MODE_ADJ_V, 1'b0, 1'b0, 1);
    applyStimulus(MODE_ADJ_V, 1'b1, 1'b0, 3);
    checkOutput("adjv_step", {23'd0, bus.val}, 1);
    applyStimulus(MODE_HOLD, 1'b1, 1'b0, 6);
    checkOutput("hold_val", {23'd0, bus.val}, 1);
    checkOutput("hold_pulse", {31'd0, bus.step_pulse}, 0);
    applyStimulus(MODE_ADJ_V, 1'b1, 1'b0, 1);
    checkOutput("adjv_change_cycle", {23'd0, bus.val}, 1);
    tick(1);
    checkOutput("adjv_return_step", {23'd0, bus.val}, 2);
    checkOutput("adjv_return_pulse", {31'd0, bus.step_pulse}, 1);

    applyStimulus(MODE_PRESET, 1'b1, 1'b0, 2);
    checkOutput("preset2_val", {23'd0, bus.val}, 50);
    checkOutput("preset2_pulse", {31'd0, bus.step_pulse}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hsv_param_ctrl.md
Name: hsv_param_ctrl

Overview:
- Button/switch-driven generator of Hue/Saturation/Value set-points for the LED colour path; sits between the board-input/mode-select logic and the HSV-to-RGB converter.
- Generalises the fixed-width, fixed-rate HSV controller: parametrised widths, ranges and rates, a press/hold auto-repeat FSM, direction control, preset restore and a clean prescaler per function.

Parameters:
- W, 9, width of hue/sat/val outputs
- HUE_MAX, 359, largest hue value; hue wraps modulo HUE_MAX+1
- SV_MAX, 100, largest sat/val value
- HUE_DEF, 120, hue used in FIXED mode and after PRESET
- SV_DEF, 50, sat/val default after PRESET
- CNT_W, 22, width of all rate counters
- STEP60_CYC, 2**22, cycles per hue step in STEP60 mode
- SWEEP_CYC, 2**19, cycles per hue step in SWEEP mode
- HOLD_CYC, 2**21, cycles a button must stay held before auto-repeat starts
- REPEAT_CYC, 2**20, cycles between auto-repeat steps

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- mode  in  3  0 FIXED, 1 STEP60, 2 SWEEP, 3 ADJ_H, 4 ADJ_S, 5 ADJ_V, 6 HOLD, 7 PRESET
- btn  in  1  adjust button, already synchronised/debounced, level
- dir  in  1  adjust direction: 0 up (+1), 1 down (-1)
- hue  out  W  hue set-point, registered
- sat  out  W  saturation set-point, registered
- val  out  W  value set-point, registered
- step_pulse  out  1  one-cycle strobe on the cycle any output changes due to a step

Behaviour:
- Reset: clk, reset synchronous active-high. hue=0, sat=0, val=0, step_pulse=0, FSM=IDLE, all counters 0. Reset wins over every other input.
- All outputs registered; a step decided in cycle n is visible after edge n+1.
- mode sampled every cycle; mode change (mode != mode_q) forces FSM to IDLE and clears rate counter that cycle; no step occurs in the change cycle.
- FIXED: hue<=HUE_DEF each cycle; sat/val hold.
- STEP60: counter counts 0..STEP60_CYC-1; on wrap to 0 hue<=hue+60; if result>HUE_MAX, result-(HUE_MAX+1).
- SWEEP: same counter with SWEEP_CYC; hue<=hue+1, HUE_MAX->0.
- ADJ_H/ADJ_S/ADJ_V: adjust FSM drives one target (hue/sat/val, range HUE_MAX or SV_MAX). Up from max->0; down from 0->max.
- Adjust FSM states:
  - IDLE: btn=1 -> step once, go PRESS, clear counter.
  - PRESS: btn=0 -> IDLE; counter reaches HOLD_CYC-1 -> step, go REPEAT, clear counter.
  - REPEAT: btn=0 -> IDLE; counter reaches REPEAT_CYC-1 -> step, clear counter.
  - btn release mid-count discards partial count; no step on release.
- dir sampled on the step cycle only; changing dir while held affects the next step.
- HOLD: all outputs frozen; FSM idle.
- PRESET: hue<=HUE_DEF, sat<=SV_DEF, val<=SV_DEF every cycle; step_pulse=0.
- Out-of-range values (reachable only via parameter misuse) wrap on next step as if >max: next up-step gives 0.
- step_pulse=1 exactly in the cycle the stepped output register updates; never in FIXED/PRESET/HOLD.

Optional Feature:
- Macro HSV_SV_CLAMP_EN. Defined: sat/val saturate (up at SV_MAX stays SV_MAX, down at 0 stays 0; step_pulse still fires). Undefined: sat/val wrap as above. Hue always wraps.

Decomposition:
- Package hsv_pkg: mode enum (FIXED..PRESET), adjust-FSM state enum, default HUE_MAX/SV_MAX constants.
- One sub-module: hsv_wrap_step (combinational value, dir, max, clamp flag -> next value), instanced for hue/sat/val.

Test Plan (STEP60_CYC=4, SWEEP_CYC=2, HOLD_CYC=5, REPEAT_CYC=3):
- reset 2 cycles, mode=PRESET 1 cycle -> hue=120, sat=50, val=50; reset mid-REPEAT -> all 0 next edge.
- mode=STEP60 from hue=300 -> hue 0 after 4 cycles, 60 after 8; step_pulse each step.
- mode=ADJ_S, dir=0, btn held 14 cycles from sat=99 -> 100 (immediate), 0 at hold (cycle 5), 1 at cycle 8, 2 at cycle 11; with HSV_SV_CLAMP_EN held at 100.
- mode=ADJ_H, dir=1, hue=0, one-cycle btn pulse -> hue=359, single step_pulse, FSM back to IDLE.
- mode switch ADJ_V->HOLD while btn held -> val frozen, no step_pulse; return to ADJ_V with btn held -> immediate step.
- mode=SWEEP from hue=358 -> 359 then 0 two cycles apart.
